// File: rtl/ofs_fim_pcie_tag_tracker_if.sv
`default_nettype none
// ============================================================================
// Module      : ofs_fim_pcie_tag_tracker_if
// Description : Request, completion and status bundle for the read tag tracker.
// Revision    : 1.0  initial release
// ============================================================================
interface ofs_fim_pcie_tag_tracker_if #(
    parameter int TAG_WIDTH    = 8,
    parameter int LEN_WIDTH    = 11,
    parameter int CREDIT_WIDTH = 15
);
    logic                    req_valid;
    logic [LEN_WIDTH-1:0]    req_len;
    logic                    req_ready;
    logic [TAG_WIDTH-1:0]    req_tag;
    logic                    cpl_valid;
    logic [TAG_WIDTH-1:0]    cpl_tag;
    logic                    cpl_last;
    logic                    err_unexp_cpl;
    logic                    err_cpl_timeout;
    logic [TAG_WIDTH-1:0]    err_tag;
    logic [TAG_WIDTH:0]      outstanding;
    logic [CREDIT_WIDTH-1:0] credit_used;

    modport master (
        output req_valid, req_len, cpl_valid, cpl_tag, cpl_last,
        input  req_ready, req_tag, err_unexp_cpl, err_cpl_timeout, err_tag,
               outstanding, credit_used
    );

    modport slave (
        input  req_valid, req_len, cpl_valid, cpl_tag, cpl_last,
        output req_ready, req_tag, err_unexp_cpl, err_cpl_timeout, err_tag,
               outstanding, credit_used
    );
endinterface
`default_nettype wire

// File: rtl/ofs_fim_pcie_tag_tracker.sv
`default_nettype none
// ============================================================================
// Module      : ofs_fim_pcie_tag_tracker
// Description : Non-posted read tag allocator with completion credit tracking,
//               unexpected-completion detection and completion timeout scan.
// Revision    : 1.0  initial release
// ============================================================================
module ofs_fim_pcie_tag_tracker #(
    parameter int NUM_TAGS     = 256,
    parameter int TAG_WIDTH    = $clog2(NUM_TAGS),
    parameter int CREDIT_DW    = 10000,
    parameter int CREDIT_WIDTH = $clog2(CREDIT_DW) + 1,
    parameter int LEN_WIDTH    = 11,
    parameter int TIMEOUT      = 12500000,
    parameter int TIME_WIDTH   = 26
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    ofs_fim_pcie_tag_tracker_if.slave  bus
);

    // Arithmetic width that holds credit_used + one request without overflow
    localparam int SUM_WIDTH = ((CREDIT_WIDTH > LEN_WIDTH) ? CREDIT_WIDTH : LEN_WIDTH) + 1;
    localparam int PAD_TAGS  = 1 << TAG_WIDTH;

    localparam logic [SUM_WIDTH-1:0]  c_credit_max = SUM_WIDTH'(CREDIT_DW);
    localparam logic [TAG_WIDTH-1:0]  c_last_tag   = TAG_WIDTH'(NUM_TAGS - 1);
    localparam logic [TAG_WIDTH:0]    c_num_tags   = (TAG_WIDTH + 1)'(NUM_TAGS);
    localparam logic [TIME_WIDTH-1:0] c_timeout    = TIME_WIDTH'(TIMEOUT);

    logic [NUM_TAGS-1:0]     r_busy;
    logic [LEN_WIDTH-1:0]    r_len [NUM_TAGS];
    logic [TIME_WIDTH-1:0]   r_ts  [NUM_TAGS];
    logic [TAG_WIDTH-1:0]    r_alloc_ptr;
    logic [TAG_WIDTH-1:0]    r_scan_ptr;
    logic [TIME_WIDTH-1:0]   r_now;
    logic [CREDIT_WIDTH-1:0] r_credit_used;
    logic [TAG_WIDTH:0]      r_outstanding;
    logic                    r_err_unexp;
    logic                    r_err_timeout;
    logic [TAG_WIDTH-1:0]    r_err_tag;

    logic [PAD_TAGS-1:0]     w_busy_pad;
    logic                    w_alloc_busy;
    logic [SUM_WIDTH-1:0]    w_credit_sum;
    logic                    w_credit_ok;
    logic                    w_req_ready;
    logic                    w_accept;
    logic                    w_cpl_in_range;
    logic                    w_cpl_busy;
    logic [TAG_WIDTH-1:0]    w_cpl_idx;
    logic                    w_retire;
    logic                    w_unexp;
    logic [TIME_WIDTH-1:0]   w_age;
    logic                    w_scan_hit;
    logic                    w_timeout;
    logic [SUM_WIDTH-1:0]    w_rel_cpl;
    logic [SUM_WIDTH-1:0]    w_rel_scan;
    logic [SUM_WIDTH-1:0]    w_credit_next;
    logic [TAG_WIDTH:0]      w_outstanding_next;
    logic [TAG_WIDTH-1:0]    w_alloc_next;
    logic [TAG_WIDTH-1:0]    w_scan_next;

    // Zero-padded copy lets out-of-range completion tags index safely
    assign w_busy_pad   = PAD_TAGS'(r_busy);
    assign w_alloc_busy = w_busy_pad[r_alloc_ptr];
    assign w_credit_sum = SUM_WIDTH'(r_credit_used) + SUM_WIDTH'(bus.req_len);
    assign w_credit_ok  = (w_credit_sum <= c_credit_max);
    assign w_req_ready  = !rst && !w_alloc_busy && w_credit_ok;
    assign w_accept     = bus.req_valid && w_req_ready;

    assign w_cpl_in_range = ({1'b0, bus.cpl_tag} < c_num_tags);
    assign w_cpl_busy     = w_cpl_in_range && w_busy_pad[bus.cpl_tag];
    assign w_cpl_idx      = w_cpl_in_range ? bus.cpl_tag : '0;
    assign w_retire       = bus.cpl_valid && w_cpl_busy && bus.cpl_last;
    assign w_unexp        = bus.cpl_valid && !w_cpl_busy;

    // Modular age keeps working across wrap of the free-running timestamp
    assign w_age      = r_now - r_ts[r_scan_ptr];
    assign w_scan_hit = w_busy_pad[r_scan_ptr] && (w_age >= c_timeout);
    assign w_timeout  = w_scan_hit && !(w_retire && (w_cpl_idx == r_scan_ptr));

    always_comb begin
        w_rel_cpl          = '0;
        w_rel_scan         = '0;
        if (w_retire) begin
            w_rel_cpl = SUM_WIDTH'(r_len[w_cpl_idx]);
        end
        if (w_timeout) begin
            w_rel_scan = SUM_WIDTH'(r_len[r_scan_ptr]);
        end
        w_credit_next      = SUM_WIDTH'(r_credit_used)
                           + (w_accept ? SUM_WIDTH'(bus.req_len) : '0)
                           - w_rel_cpl - w_rel_scan;
        w_outstanding_next = r_outstanding
                           + (TAG_WIDTH + 1)'(w_accept)
                           - (TAG_WIDTH + 1)'(w_retire)
                           - (TAG_WIDTH + 1)'(w_timeout);
        w_alloc_next       = (r_alloc_ptr == c_last_tag) ? '0 : r_alloc_ptr + TAG_WIDTH'(1);
        w_scan_next        = (r_scan_ptr == c_last_tag) ? '0 : r_scan_ptr + TAG_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy        <= '0;
            r_alloc_ptr   <= '0;
            r_scan_ptr    <= '0;
            r_now         <= '0;
            r_credit_used <= '0;
            r_outstanding <= '0;
            r_err_unexp   <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_tag     <= '0;
        end else begin
            for (int i = 0; i < NUM_TAGS; i++) begin
                if (w_accept && (r_alloc_ptr == TAG_WIDTH'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if ((w_retire && (w_cpl_idx == TAG_WIDTH'(i))) ||
                             (w_timeout && (r_scan_ptr == TAG_WIDTH'(i)))) begin
                    r_busy[i] <= 1'b0;
                end
            end
            // Pointer also skips over busy slots while hunting for a free tag
            if (w_accept || w_alloc_busy) begin
                r_alloc_ptr <= w_alloc_next;
            end
            r_scan_ptr    <= w_scan_next;
            r_now         <= r_now + TIME_WIDTH'(1);
            r_credit_used <= CREDIT_WIDTH'(w_credit_next);
            r_outstanding <= w_outstanding_next;
            r_err_unexp   <= w_unexp;
            r_err_timeout <= w_timeout;
            if (w_unexp) begin
                r_err_tag <= bus.cpl_tag;
            end else if (w_timeout) begin
                r_err_tag <= r_scan_ptr;
            end
        end
    end

    // Per-tag payload needs no reset: it is only read while the busy bit is set
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_len[r_alloc_ptr] <= bus.req_len;
            r_ts[r_alloc_ptr]  <= r_now;
        end
    end

    assign bus.req_ready       = w_req_ready;
    assign bus.req_tag         = r_alloc_ptr;
    assign bus.err_unexp_cpl   = r_err_unexp;
    assign bus.err_cpl_timeout = r_err_timeout;
    assign bus.err_tag         = r_err_tag;
    assign bus.outstanding     = r_outstanding;
    assign bus.credit_used     = r_credit_used;

endmodule
`default_nettype wire

// File: tb/tb_ofs_fim_pcie_tag_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_ofs_fim_pcie_tag_tracker
// Description : Directed self-checking bench for the PCIe read tag tracker.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ofs_fim_pcie_tag_tracker;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    // a: 8 tags, short timeout; b: 64 DW credit; c: 6 tags (non power of two)
    ofs_fim_pcie_tag_tracker_if #(.TAG_WIDTH(3), .LEN_WIDTH(11), .CREDIT_WIDTH(15)) ifa ();
    ofs_fim_pcie_tag_tracker_if #(.TAG_WIDTH(3), .LEN_WIDTH(11), .CREDIT_WIDTH(7))  ifb ();
    ofs_fim_pcie_tag_tracker_if #(.TAG_WIDTH(3), .LEN_WIDTH(11), .CREDIT_WIDTH(15)) ifc ();

    ofs_fim_pcie_tag_tracker #(.NUM_TAGS(8), .TIMEOUT(256)) dut_a (
        .clk(clk), .rst(rst_a), .bus(ifa));
    ofs_fim_pcie_tag_tracker #(.NUM_TAGS(8), .CREDIT_DW(64)) dut_b (
        .clk(clk), .rst(rst_b), .bus(ifb));
    ofs_fim_pcie_tag_tracker #(.NUM_TAGS(6)) dut_c (
        .clk(clk), .rst(rst_c), .bus(ifc));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int first_k;
    int pulses;
    logic [31:0] to_tag, to_cred, to_out;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        ifa.req_valid = 1'b1; ifa.req_len = 11'd16;
        ifa.cpl_valid = 1'b0; ifa.cpl_tag = 3'd0; ifa.cpl_last = 1'b0;
        ifb.req_valid = 1'b0; ifb.req_len = 11'd32;
        ifb.cpl_valid = 1'b0; ifb.cpl_tag = 3'd0; ifb.cpl_last = 1'b0;
        ifc.req_valid = 1'b0; ifc.req_len = 11'd2;
        ifc.cpl_valid = 1'b0; ifc.cpl_tag = 3'd0; ifc.cpl_last = 1'b0;

        // Reset values, request offered while in reset
        repeat (3) tick();
        #1;
        check("a_rst_ready",   32'(ifa.req_ready), 0);
        check("a_rst_tag",     32'(ifa.req_tag), 0);
        check("a_rst_unexp",   32'(ifa.err_unexp_cpl), 0);
        check("a_rst_timeout", 32'(ifa.err_cpl_timeout), 0);
        check("a_rst_err_tag", 32'(ifa.err_tag), 0);
        check("a_rst_out",     32'(ifa.outstanding), 0);
        check("a_rst_credit",  32'(ifa.credit_used), 0);
        check("c_rst_out",     32'(ifc.outstanding), 0);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        // Eight reads of 16 DW take tags 0..7
        for (int i = 0; i < 8; i++) begin
            #1;
            check("a_fill_ready", 32'(ifa.req_ready), 1);
            check("a_fill_tag",   32'(ifa.req_tag), 32'(i));
            tick();
        end
        #1;
        check("a_full_ready",  32'(ifa.req_ready), 0);
        check("a_full_out",    32'(ifa.outstanding), 8);
        check("a_full_credit", 32'(ifa.credit_used), 128);
        repeat (3) tick();
        check("a_stall_ready", 32'(ifa.req_ready), 0);

        // Non-final completion leaves state untouched
        ifa.cpl_valid = 1'b1; ifa.cpl_tag = 3'd2; ifa.cpl_last = 1'b0;
        tick();
        ifa.cpl_valid = 1'b0;
        #1;
        check("a_partial_out",   32'(ifa.outstanding), 8);
        check("a_partial_unexp", 32'(ifa.err_unexp_cpl), 0);

        // Final completion on tag 3 frees it for the stalled ninth request
        ifa.cpl_valid = 1'b1; ifa.cpl_tag = 3'd3; ifa.cpl_last = 1'b1;
        tick();
        ifa.cpl_valid = 1'b0;
        #1;
        check("a_retire_out",    32'(ifa.outstanding), 7);
        check("a_retire_credit", 32'(ifa.credit_used), 112);
        for (int k = 0; k < 16 && !ifa.req_ready; k++) begin
            tick();
            #1;
        end
        check("a_9th_ready", 32'(ifa.req_ready), 1);
        check("a_9th_tag",   32'(ifa.req_tag), 3);
        tick();
        ifa.req_valid = 1'b0;
        #1;
        check("a_9th_out",    32'(ifa.outstanding), 8);
        check("a_9th_credit", 32'(ifa.credit_used), 128);

        for (int t = 0; t < 8; t++) begin
            ifa.cpl_valid = 1'b1; ifa.cpl_tag = 3'(t); ifa.cpl_last = 1'b1;
            tick();
        end
        ifa.cpl_valid = 1'b0;
        #1;
        check("a_drain_out",     32'(ifa.outstanding), 0);
        check("a_drain_credit",  32'(ifa.credit_used), 0);
        check("a_drain_unexp",   32'(ifa.err_unexp_cpl), 0);
        check("a_drain_timeout", 32'(ifa.err_cpl_timeout), 0);

        // Completion on an idle tag
        ifa.cpl_valid = 1'b1; ifa.cpl_tag = 3'd5; ifa.cpl_last = 1'b0;
        tick();
        ifa.cpl_valid = 1'b0;
        #1;
        check("a_unexp_pulse",  32'(ifa.err_unexp_cpl), 1);
        check("a_unexp_tag",    32'(ifa.err_tag), 5);
        check("a_unexp_out",    32'(ifa.outstanding), 0);
        check("a_unexp_credit", 32'(ifa.credit_used), 0);
        tick();
        check("a_unexp_clear",  32'(ifa.err_unexp_cpl), 0);

        // Timeout: one read on tag 0, no completion
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0; ifa.req_valid = 1'b1; ifa.req_len = 11'd8;
        #1;
        check("a_to_ready", 32'(ifa.req_ready), 1);
        check("a_to_tag",   32'(ifa.req_tag), 0);
        tick();
        ifa.req_valid = 1'b0;
        first_k = -1; pulses = 0; to_tag = '1; to_cred = '1; to_out = '1;
        for (int k = 1; k <= 300; k++) begin
            tick();
            if (ifa.err_cpl_timeout) begin
                pulses++;
                if (first_k < 0) begin
                    first_k = k;
                    to_tag  = 32'(ifa.err_tag);
                    to_cred = 32'(ifa.credit_used);
                    to_out  = 32'(ifa.outstanding);
                end
            end
        end
        check("a_to_pulses", 32'(pulses), 1);
        check("a_to_window", 32'(first_k >= 256 && first_k <= 265), 1);
        check("a_to_err_tag", to_tag, 0);
        check("a_to_credit",  to_cred, 0);
        check("a_to_out",     to_out, 0);
        ifa.cpl_valid = 1'b1; ifa.cpl_tag = 3'd0; ifa.cpl_last = 1'b1;
        tick();
        ifa.cpl_valid = 1'b0;
        #1;
        check("a_late_unexp", 32'(ifa.err_unexp_cpl), 1);
        check("a_late_tag",   32'(ifa.err_tag), 0);

        // Retire lands in the very cycle the scan would time tag 0 out
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0; ifa.req_valid = 1'b1; ifa.req_len = 11'd4;
        tick();
        ifa.req_valid = 1'b0;
        #1;
        check("a_race_out0",    32'(ifa.outstanding), 1);
        check("a_race_credit0", 32'(ifa.credit_used), 4);
        repeat (255) tick();
        check("a_race_pre_to",  32'(ifa.err_cpl_timeout), 0);
        ifa.cpl_valid = 1'b1; ifa.cpl_tag = 3'd0; ifa.cpl_last = 1'b1;
        tick();
        ifa.cpl_valid = 1'b0;
        #1;
        check("a_race_timeout", 32'(ifa.err_cpl_timeout), 0);
        check("a_race_unexp",   32'(ifa.err_unexp_cpl), 0);
        check("a_race_out",     32'(ifa.outstanding), 0);
        check("a_race_credit",  32'(ifa.credit_used), 0);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (ifa.err_cpl_timeout) pulses++;
        end
        check("a_race_quiet", 32'(pulses), 0);

        // Credit limit: 32 + 32 fills 64 DW, a 1 DW read must wait
        ifb.req_valid = 1'b1; ifb.req_len = 11'd32;
        #1;
        check("b_r0_ready", 32'(ifb.req_ready), 1);
        check("b_r0_tag",   32'(ifb.req_tag), 0);
        tick();
        check("b_r1_ready", 32'(ifb.req_ready), 1);
        check("b_r1_tag",   32'(ifb.req_tag), 1);
        tick();
        ifb.req_len = 11'd1;
        #1;
        check("b_stall_ready",  32'(ifb.req_ready), 0);
        check("b_stall_credit", 32'(ifb.credit_used), 64);
        tick();
        check("b_stall_ready2", 32'(ifb.req_ready), 0);
        ifb.cpl_valid = 1'b1; ifb.cpl_tag = 3'd0; ifb.cpl_last = 1'b1;
        tick();
        ifb.cpl_valid = 1'b0;
        #1;
        check("b_free_credit", 32'(ifb.credit_used), 32);
        check("b_free_ready",  32'(ifb.req_ready), 1);
        check("b_free_tag",    32'(ifb.req_tag), 2);
        tick();
        ifb.req_valid = 1'b0;
        #1;
        check("b_final_credit", 32'(ifb.credit_used), 33);
        check("b_final_out",    32'(ifb.outstanding), 2);

        // Six tags: allocate and retire back-to-back, tags wrap after 5
        for (int i = 0; i < 14; i++) begin
            ifc.req_valid = 1'b1; ifc.req_len = 11'd2;
            ifc.cpl_valid = (i > 0); ifc.cpl_tag = 3'((i + 5) % 6); ifc.cpl_last = 1'b1;
            #1;
            check("c_seq_ready",  32'(ifc.req_ready), 1);
            check("c_seq_tag",    32'(ifc.req_tag), 32'(i % 6));
            check("c_seq_out",    32'(ifc.outstanding), (i > 0) ? 1 : 0);
            check("c_seq_credit", 32'(ifc.credit_used), (i > 0) ? 2 : 0);
            check("c_seq_unexp",  32'(ifc.err_unexp_cpl), 0);
            tick();
        end
        ifc.req_valid = 1'b0;
        ifc.cpl_valid = 1'b1; ifc.cpl_tag = 3'd7; ifc.cpl_last = 1'b1;
        tick();
        ifc.cpl_valid = 1'b0;
        #1;
        check("c_oor_unexp", 32'(ifc.err_unexp_cpl), 1);
        check("c_oor_tag",   32'(ifc.err_tag), 7);
        check("c_oor_out",   32'(ifc.outstanding), 1);

        // Mid-stream reset drops the outstanding tag silently
        rst_c = 1'b1; ifc.req_valid = 1'b1;
        #1;
        check("c_rst_comb_ready", 32'(ifc.req_ready), 0);
        tick();
        check("c_rst_ready",   32'(ifc.req_ready), 0);
        check("c_rst_tag",     32'(ifc.req_tag), 0);
        check("c_rst_out2",    32'(ifc.outstanding), 0);
        check("c_rst_credit",  32'(ifc.credit_used), 0);
        check("c_rst_err_tag", 32'(ifc.err_tag), 0);
        check("c_rst_unexp",   32'(ifc.err_unexp_cpl), 0);
        check("c_rst_timeout", 32'(ifc.err_cpl_timeout), 0);
        rst_c = 1'b0;
        #1;
        check("c_post_ready", 32'(ifc.req_ready), 1);
        check("c_post_tag",   32'(ifc.req_tag), 0);
        ifc.req_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ofs_fim_pcie_tag_tracker.md
# ofs_fim_pcie_tag_tracker

Non-posted read tracker for the PCIe subsystem TX path: allocates TLP tags for outgoing memory reads, reserves completion buffer credit in DW, and retires tags as completions arrive on the RX path. It flags completions whose tags have no outstanding request. It also flags reads whose completions do not arrive in time. It sits between the TX request arbiter, which feeds it requests, and the AVST TX bridge. Its error pulses feed the err_unexp_cpl and err_cpl_timeout bits of the PCIe error vector.

## Interface
- NUM_TAGS, 256, tag space size; must be at least 2 and may be a non-power-of-2.
- TAG_WIDTH, $clog2(NUM_TAGS), tag width.
- CREDIT_DW, 10000, completion buffer capacity in DW (2500 x 4DW).
- CREDIT_WIDTH, $clog2(CREDIT_DW)+1, width of credit counters.
- LEN_WIDTH, 11, request/completion length width in DW (1..1024).
- TIMEOUT, 12500000, completion timeout in clk cycles; must be below 2^TIME_WIDTH.
- TIME_WIDTH, 26, timestamp width.
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  read request offered.
- req_len  in  LEN_WIDTH  requested length in DW; must be 1..1024.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_tag  out  TAG_WIDTH  tag granted to the accepted request.
- cpl_valid  in  1  completion TLP header observed (one per TLP).
- cpl_tag  in  TAG_WIDTH  completion tag.
- cpl_last  in  1  final completion for that request.
- err_unexp_cpl  out  1  one-cycle pulse for an unexpected completion.
- err_cpl_timeout  out  1  one-cycle pulse when a tag times out.
- err_tag  out  TAG_WIDTH  tag associated with the most recent error pulse.
- outstanding  out  TAG_WIDTH+1  count of tags in use.
- credit_used  out  CREDIT_WIDTH  DW currently reserved.

## Operation
- Per-tag state, indexed by tag:
  - busy bit;
  - reserved length (LEN_WIDTH);
  - issue timestamp (TIME_WIDTH).
- now: free-running TIME_WIDTH counter that wraps modulo 2^TIME_WIDTH.
- Allocation:
  - alloc_ptr points at the candidate tag.
  - When busy[alloc_ptr] is set, alloc_ptr advances by one each cycle until it finds a free tag.
  - alloc_ptr wraps from NUM_TAGS-1 to 0.
- req_ready = !rst && !busy[alloc_ptr] && (credit_used + req_len <= CREDIT_DW). req_tag = alloc_ptr.
- On accept:
  - set busy;
  - store len and now;
  - credit_used += req_len;
  - alloc_ptr advances with wrap.
- Completion:
  - cpl_valid on a tag that is not busy: pulse err_unexp_cpl, err_tag = cpl_tag. No state change.
  - cpl_valid on a busy tag with cpl_last=0: no state change.
  - cpl_valid on a busy tag with cpl_last=1: clear busy and release the stored len from credit_used.
  - Completions with an out-of-range tag (>= NUM_TAGS) are treated as unexpected.
- Timeout scan:
  - scan_ptr visits one tag per cycle and wraps at NUM_TAGS-1.
  - If busy[scan_ptr] and (now - ts[scan_ptr]) mod 2^TIME_WIDTH >= TIMEOUT:
    - clear busy;
    - release len;
    - pulse err_cpl_timeout, err_tag = scan_ptr.
- Simultaneous events:
  - Completion retire and timeout on the same tag in the same cycle: the completion wins and no timeout is reported.
  - Accept and release in the same cycle: credit_used += req_len - released_len.
  - A completion to the tag being allocated in the same cycle is unexpected, because busy is sampled before the update.
  - Unexpected-completion and timeout errors in the same cycle: both pulses fire and err_tag takes the cpl_tag value.
- A completion arriving after its tag has timed out is reported as unexpected.

## Timing
- req_ready and req_tag are combinational from registered state and req_len. The tag and its credit take effect on the clock edge of acceptance.
- A retire from cpl_valid is visible in busy, credit_used and outstanding on the next cycle. The freed credit can be used on that cycle. The freed tag becomes grantable when alloc_ptr reaches it.
- err_* pulses are registered and appear 1 cycle after the triggering cpl_valid or scan hit.
- Timeout detection latency, measured from acceptance: between TIMEOUT and TIMEOUT+NUM_TAGS+1 cycles.
- Reset values:
  - req_ready=0, req_tag=0;
  - err_unexp_cpl=0, err_cpl_timeout=0, err_tag=0;
  - outstanding=0, credit_used=0;
  - all busy bits 0, alloc_ptr=0, scan_ptr=0, now=0.
- Reset asserted mid-operation drops all outstanding tags silently: no error pulses and no credit release events.

## Test plan
- NUM_TAGS=8, TIMEOUT=256: issue 8 reads of len 16.
  - Tags granted are 0..7 and outstanding=8, credit_used=128.
  - The 9th request stalls (req_ready=0) until the completion for tag 3 (cpl_last=1).
  - The 9th request is then granted tag 3.
- CREDIT_DW=64: reads of len 32, 32, 1.
  - The third request stalls with credit_used=64.
  - A cpl_last on the first tag gives credit_used=32 on the next cycle, and the third request is then granted.
- cpl_valid with tag 5 while tag 5 is idle → err_unexp_cpl=1 for 1 cycle, err_tag=5, no counter change.
- NUM_TAGS=8, TIMEOUT=256: issue one read (tag 0) and send no completion.
  - err_cpl_timeout pulses once, between 256 and 265 cycles after acceptance, with err_tag=0 and credit_used=0.
  - A later completion on tag 0 → err_unexp_cpl.
- Completion retire and scan hit on the same tag in the same cycle → retire only, with no err_cpl_timeout.
- NUM_TAGS=6: allocate and retire 14 requests back-to-back → req_tag sequence 0..5,0..5,0,1 (wrap at 5). Then assert rst mid-stream → all outputs return to their reset values on the next cycle.
